// File: rtl/fetch_pkg.sv
// Shared defaults and entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned ILEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        push_data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;

  assign full    = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(push_i && !flush_i && full));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC sequencing, 1-cycle imem requests with credit check, redirect flush.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned     PC_STEP  = 4,
  parameter int unsigned     FQ_DEPTH = 4,
  localparam int unsigned    CW       = $clog2(FQ_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready,
  output logic [CW-1:0]   fq_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(PC_STEP) - XLEN'(1));

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            running_q;
  logic            inflight_q, inflight_d;
  logic            credit_ok;
  logic            issue;
  logic            push, pop;
  entry_t          push_data, head;

  // Credit counts the outstanding response but not a same-cycle pop.
  assign credit_ok = (fq_count + CW'(inflight_q)) < CW'(FQ_DEPTH);
  assign issue     = running_q & fetch_en & ~redirect_valid & credit_ok;
  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  assign push      = inflight_q & ~redirect_valid;
  assign pop       = out_valid & out_ready & ~redirect_valid;
  assign push_data = '{pc: inflight_pc_q, instr: imem_rdata};
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + STEP;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      running_q     <= 1'b0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      running_q     <= 1'b1;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (out_valid),
    .count_o     (fq_count)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; a second instance checks a non-zero reset vector.
module tb_instr_fetch_queue;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset, fetch_en, redirect_valid, out_ready;
  logic [31:0] redirect_pc;

  logic        a_req, a_valid, b_req, b_valid;
  logic [31:0] a_addr, a_rdata, a_instr, a_pc;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc;
  logic [2:0]  a_cnt, b_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_queue u_dut_a (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .out_valid(a_valid), .out_instr(a_instr), .out_pc(a_pc),
    .out_ready(out_ready), .fq_count(a_cnt)
  );

  instr_fetch_queue #(.RESET_PC(32'h8000_0000)) u_dut_b (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .out_valid(b_valid), .out_instr(b_instr), .out_pc(b_pc),
    .out_ready(out_ready), .fq_count(b_cnt)
  );

  // 1-cycle latency instruction memory: word = addr ^ K
  always @(posedge clk) begin
    a_rdata <= a_addr ^ K;
    b_rdata <= b_addr ^ K;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic restart(input logic ready);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = ready;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", a_req, 0);
    check("rst_valid", a_valid, 0);
    check("rst_cnt", a_cnt, 0);

    // streaming from reset
    @(negedge clk); reset = 1'b1;
    #1 check("pre_run_req", a_req, 0);
    cyc(); #1;
    check("first_req", a_req, 1);
    check("first_addr", a_addr, 32'h0);
    check("b_first_addr", b_addr, 32'h8000_0000);
    check("first_nvalid", a_valid, 0);
    cyc(); #1;
    check("second_addr", a_addr, 32'h4);
    check("lat_nvalid", a_valid, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      check($sformatf("stream_valid%0d", k), a_valid, 1);
      check($sformatf("stream_pc%0d", k), a_pc, 32'(4 * k));
      check($sformatf("stream_instr%0d", k), a_instr, 32'(4 * k) ^ K);
      if (k < 2) check($sformatf("b_pc%0d", k), b_pc, 32'h8000_0000 + 32'(4 * k));
    end

    // backpressure fills the queue, then drains with no gap
    restart(1'b0);
    repeat (10) cyc();
    #1;
    check("stall_cnt", a_cnt, 4);
    check("stall_req", a_req, 0);
    check("stall_pc", a_pc, 32'h0);
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_valid%0d", k), a_valid, 1);
      check($sformatf("drain_pc%0d", k), a_pc, 32'(4 * k));
      cyc(); #1;
    end

    // redirect with 3 queued entries and one in flight
    restart(1'b0);
    repeat (5) cyc();
    #1;
    check("pre_rd_cnt", a_cnt, 3);
    check("pre_rd_req", a_req, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h1003;
    #1 check("rd_noreq", a_req, 0);
    cyc(); redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rd_flush_valid", a_valid, 0);
    check("rd_flush_cnt", a_cnt, 0);
    check("rd_req", a_req, 1);
    check("rd_addr", a_addr, 32'h1000);
    cyc(); #1;
    check("rd_nvalid", a_valid, 0);
    check("rd_addr2", a_addr, 32'h1004);
    cyc(); #1;
    check("rd_valid", a_valid, 1);
    check("rd_pc0", a_pc, 32'h1000);
    check("rd_instr0", a_instr, 32'h1000 ^ K);
    cyc(); #1;
    check("rd_pc1", a_pc, 32'h1004);

    // redirect near the top of the address space wraps to zero
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1 check("wrap_noreq", a_req, 0);
    cyc(); redirect_valid = 1'b0;
    #1 check("wrap_addr0", a_addr, 32'hFFFF_FFFC);
    cyc(); #1 check("wrap_addr1", a_addr, 32'h0);
    cyc(); #1 check("wrap_pc0", a_pc, 32'hFFFF_FFFC);
    cyc(); #1 check("wrap_pc1", a_pc, 32'h0);

    // fetch_en dropped with a request in flight
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h2000;
    cyc(); redirect_valid = 1'b0;
    cyc();
    cyc(); fetch_en = 1'b0;
    #1;
    check("halt_noreq", a_req, 0);
    check("halt_pc0", a_pc, 32'h2000);
    cyc(); #1;
    check("halt_valid1", a_valid, 1);
    check("halt_pc1", a_pc, 32'h2004);
    cyc(); #1;
    check("halt_drained", a_valid, 0);
    check("halt_cnt", a_cnt, 0);
    check("halt_req", a_req, 0);
    cyc(); fetch_en = 1'b1;
    #1;
    check("resume_req", a_req, 1);
    check("resume_addr", a_addr, 32'h2008);
    cyc(); cyc(); #1;
    check("resume_pc", a_pc, 32'h2008);

    // asynchronous reset mid-stream
    restart(1'b0);
    repeat (5) cyc();
    #1;
    check("mid_cnt", a_cnt, 3);
    check("b_mid_cnt", b_cnt, 3);
    reset = 1'b0;
    #1;
    check("arst_valid", a_valid, 0);
    check("arst_req", a_req, 0);
    check("arst_cnt", a_cnt, 0);
    check("b_arst_cnt", b_cnt, 0);
    cyc(); reset = 1'b1; out_ready = 1'b1;
    cyc(); #1;
    check("rerun_addr", a_addr, 32'h0);
    check("rerun_req", a_req, 1);
    check("b_rerun_addr", b_addr, 32'h8000_0000);
    cyc(); cyc(); #1;
    check("rerun_pc", a_pc, 32'h0);
    check("b_rerun_pc", b_pc, 32'h8000_0000);
    check("b_rerun_instr", b_instr, 32'h8000_0000 ^ K);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
